// File: rtl/adj_feature_aggregator.sv
// ----------------------------------------------------------------------------
// adj_feature_aggregator
//   Graph-convolution aggregation stage. On agg_start (accepted in IDLE only)
//   the N x N adjacency matrix and the node feature matrix X are captured,
//   then AGG = (A + I*ADD_SELF_LOOP) * X is built one adjacency entry (i,j)
//   per cycle. Each finished row is written to agg_mat as soon as its last
//   column has been visited; agg_done pulses once when the whole matrix is
//   valid.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (priority over everything)
//   agg_start  start request, ignored unless IDLE
//   adj_mat    adjacency rows, adj_mat[i][j]=1 means edge i-j
//   feat_mat   packed feature matrix, feat_mat[node][feature]
//   agg_mat    aggregated features, row i = sum of X[j] over neighbours j
//   agg_busy   high while accumulating and in the done cycle
//   agg_done   one-cycle pulse, agg_mat valid from this cycle
// ----------------------------------------------------------------------------
module adj_feature_aggregator #(
   parameter  int NUM_OF_NODES    = 6,
   parameter  int NUM_OF_FEATURES = 3,
   parameter  int FEATURE_WIDTH   = 5,
   parameter  int ADD_SELF_LOOP   = 1,
   localparam int ACC_WIDTH       = FEATURE_WIDTH + $clog2(NUM_OF_NODES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic agg_start,
   input  logic [NUM_OF_NODES-1:0] adj_mat [NUM_OF_NODES-1:0],
   input  logic [NUM_OF_NODES-1:0][NUM_OF_FEATURES-1:0][FEATURE_WIDTH-1:0] feat_mat,
   output logic [NUM_OF_NODES-1:0][NUM_OF_FEATURES-1:0][ACC_WIDTH-1:0]     agg_mat,
   output logic agg_busy,
   output logic agg_done
);

   localparam int IDX_W = (NUM_OF_NODES > 1) ? $clog2(NUM_OF_NODES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OF_NODES - 1);
   localparam bit SELF_LOOP = (ADD_SELF_LOOP != 0);

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

   state_t state, state_nxt;

   logic [NUM_OF_NODES-1:0] adj_copy [NUM_OF_NODES-1:0];
   logic [NUM_OF_NODES-1:0][NUM_OF_FEATURES-1:0][FEATURE_WIDTH-1:0] feat_copy;
   logic [NUM_OF_FEATURES-1:0][ACC_WIDTH-1:0] acc;
   logic [NUM_OF_FEATURES-1:0][ACC_WIDTH-1:0] acc_nxt;
   logic [IDX_W-1:0] i_cnt;
   logic [IDX_W-1:0] j_cnt;
   logic             hit;
   logic             last_col;
   logic             last_row;

   assign last_col = (j_cnt == LAST_IDX);
   assign last_row = (i_cnt == LAST_IDX);

   // Diagonal input bits are ORed with the self-loop term so a node that
   // already lists itself as a neighbour is counted once.
   assign hit = adj_copy[i_cnt][j_cnt] | (SELF_LOOP & (i_cnt == j_cnt));

   // ---- entry evaluation: running row sum including entry (i,j) ----
   always_comb begin
      for (int f = 0; f < NUM_OF_FEATURES; f++) begin
         acc_nxt[f] = acc[f];
         if (hit) begin
            acc_nxt[f] = acc[f] + ACC_WIDTH'(feat_copy[j_cnt][f]);
         end
      end
   end

   // ---- FSM state register ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---- FSM next state ----
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (agg_start) state_nxt = S_ACC;
         S_ACC:   if (last_row && last_col) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---- FSM outputs ----
   always_comb begin
      agg_busy = 1'b0;
      agg_done = 1'b0;
      case (state)
         S_ACC:   agg_busy = 1'b1;
         S_DONE: begin
            agg_busy = 1'b1;
            agg_done = 1'b1;
         end
         default: ;
      endcase
   end

   // ---- capture / accumulate / row write-back ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         agg_mat <= '0;
         acc     <= '0;
         i_cnt   <= '0;
         j_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (agg_start) begin
                  adj_copy  <= adj_mat;
                  feat_copy <= feat_mat;
                  acc       <= '0;
                  i_cnt     <= '0;
                  j_cnt     <= '0;
               end
            end
            S_ACC: begin
               if (last_col) begin
                  agg_mat[i_cnt] <= acc_nxt;
                  acc            <= '0;
                  j_cnt          <= '0;
                  i_cnt          <= last_row ? '0 : i_cnt + IDX_W'(1);
               end else begin
                  acc   <= acc_nxt;
                  j_cnt <= j_cnt + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
